mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the IF stage (instruction fetch, read-only) and the MEM stage (lw/sw).
- Issues one memory transaction at a time.
- Returns read data to the requester that owns the transaction.
- Drives per-requester stall lines. The hazard logic ORs these into its PC/IFID write enables and its NOP insertion.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported I/D memory between IF fetch and MEM load/store.
// Define ARB_RR_EN for round-robin priority; default build is fixed DM-over-IF priority.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic          grant_dm;

`ifdef ARB_RR_EN
  // 1 = DM won the most recent arbitration, 0 = IF
  logic last_grant_q, last_grant_d;

  assign grant_dm = dm_req & (~if_req | ~last_grant_q);
`else
  assign grant_dm = dm_req;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d     = GRANT_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
`ifdef ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (if_req) begin
          state_d     = GRANT_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
`ifdef ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end

      GRANT_IF: begin
        if (mem_ack) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
          if_done_d  = 1'b1;
        end
      end

      GRANT_DM: begin
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          dm_done_d = 1'b1;
          // stores leave the load-data register untouched
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // reset discards any in-flight transaction, so a late ack finds us in IDLE
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;

  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model plus
// a latency-configurable memory responder; honours ARB_RR_EN when defined.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          dm_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock    (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .if_stall (if_stall),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_done  (dm_done),
    .dm_stall (dm_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // environment memory (answered by the responder) and reference memory (model)
  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  int          mem_lat   = 1;
  bit          auto_mem  = 1'b1;
  bit          force_ack = 1'b0;
  logic [31:0] force_rdata = '0;
  int          resp_cnt  = 0;

  logic [31:0] m_if_rdata;
  logic [31:0] m_dm_rdata;
  logic [31:0] m_last_addr;
  bit          m_last_dm;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mem_store[a] = d;
    ref_mem[a]   = d;
  endtask

  task automatic model_reset();
    m_if_rdata  = '0;
    m_dm_rdata  = '0;
    m_last_addr = '0;
    m_last_dm   = 1'b0;
  endtask

  // memory responder: acks mem_lat cycles after mem_req rises, acts just after negedge
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (auto_mem) begin
        mem_ack = 1'b0;
        if (mem_req === 1'b1) begin
          resp_cnt++;
          if (resp_cnt >= mem_lat) begin
            mem_ack  = 1'b1;
            resp_cnt = 0;
            if (mem_we) begin
              mem_store[mem_addr] = mem_wdata;
              mem_rdata = $urandom();
            end else begin
              mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_word(mem_addr);
            end
          end
        end else begin
          resp_cnt = 0;
        end
      end else begin
        resp_cnt  = 0;
        mem_ack   = force_ack;
        mem_rdata = force_rdata;
      end
    end
  end

  task automatic do_reset();
    if_req = 1'b0;
    dm_req = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One request set, run to completion; expected order and timing come from the model.
  task automatic run_txn(input string tag, input bit want_if, input bit want_dm, input bit we,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                         input int lat);
    bit if_p, dm_p, own_dm, exp_if_done, exp_dm_done, exp_req;
    int cyc, gstart, exp_cyc;
    logic [31:0] exp_addr;
    mem_lat = lat;
    if_p = want_if;
    dm_p = want_dm;
`ifdef ARB_RR_EN
    own_dm = want_dm && (!want_if || !m_last_dm);
`else
    own_dm = want_dm;
`endif
    if (if_p || dm_p) begin
      m_last_dm   = own_dm;
      m_last_addr = own_dm ? da : ia;
    end
    gstart  = 1;
    exp_cyc = 1 + lat;
    if_req = want_if; if_addr = ia;
    dm_req = want_dm; dm_we = we; dm_addr = da; dm_wdata = wd;
    cyc = 0;
    while ((if_p || dm_p) && cyc < 80) begin
      @(negedge clk);
      cyc++;
      exp_req     = (cyc >= gstart) && (cyc < exp_cyc);
      exp_if_done = if_p && !own_dm && (cyc == exp_cyc);
      exp_dm_done = dm_p && own_dm && (cyc == exp_cyc);
      exp_addr    = own_dm ? da : ia;

      n_checks++;
      if (mem_req !== exp_req) begin
        n_fail++;
        $display("FAIL %s mem_req cyc=%0d got=%b exp=%b", tag, cyc, mem_req, exp_req);
      end
      if (exp_req) begin
        n_checks++;
        if (mem_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL %s mem_addr cyc=%0d got=%h exp=%h", tag, cyc, mem_addr, exp_addr);
        end
        n_checks++;
        if (mem_we !== (own_dm ? we : 1'b0)) begin
          n_fail++;
          $display("FAIL %s mem_we cyc=%0d got=%b exp=%b", tag, cyc, mem_we, own_dm ? we : 1'b0);
        end
        if (own_dm && we) begin
          n_checks++;
          if (mem_wdata !== wd) begin
            n_fail++;
            $display("FAIL %s mem_wdata cyc=%0d got=%h exp=%h", tag, cyc, mem_wdata, wd);
          end
        end
      end
      n_checks++;
      if (if_done !== exp_if_done) begin
        n_fail++;
        $display("FAIL %s if_done cyc=%0d got=%b exp=%b", tag, cyc, if_done, exp_if_done);
      end
      n_checks++;
      if (dm_done !== exp_dm_done) begin
        n_fail++;
        $display("FAIL %s dm_done cyc=%0d got=%b exp=%b", tag, cyc, dm_done, exp_dm_done);
      end
      n_checks++;
      if (if_stall !== (if_p && !exp_if_done)) begin
        n_fail++;
        $display("FAIL %s if_stall cyc=%0d got=%b exp=%b", tag, cyc, if_stall, if_p && !exp_if_done);
      end
      n_checks++;
      if (dm_stall !== (dm_p && !exp_dm_done)) begin
        n_fail++;
        $display("FAIL %s dm_stall cyc=%0d got=%b exp=%b", tag, cyc, dm_stall, dm_p && !exp_dm_done);
      end

      if (exp_if_done) begin
        m_if_rdata = ref_read(ia);
        if_p = 1'b0;
      end
      if (exp_dm_done) begin
        if (we) ref_mem[da] = wd;
        else    m_dm_rdata = ref_read(da);
        dm_p = 1'b0;
      end
      n_checks++;
      if (if_rdata !== m_if_rdata) begin
        n_fail++;
        $display("FAIL %s if_rdata cyc=%0d got=%h exp=%h", tag, cyc, if_rdata, m_if_rdata);
      end
      n_checks++;
      if (dm_rdata !== m_dm_rdata) begin
        n_fail++;
        $display("FAIL %s dm_rdata cyc=%0d got=%h exp=%h", tag, cyc, dm_rdata, m_dm_rdata);
      end

      if (exp_if_done || exp_dm_done) begin
        if_req = if_p;
        dm_req = dm_p;
        if (if_p || dm_p) begin
          own_dm      = dm_p;
          m_last_dm   = own_dm;
          m_last_addr = own_dm ? da : ia;
          gstart      = cyc + 2;
          exp_cyc     = gstart + lat;
        end
      end
    end
    n_checks++;
    if (if_p || dm_p) begin
      n_fail++;
      $display("FAIL %s timeout pending_if=%b pending_dm=%b exp=none", tag, if_p, dm_p);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({if_done, dm_done, mem_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s post_idle got if_done=%b dm_done=%b mem_req=%b exp=000", tag, if_done, dm_done, mem_req);
    end
    $display("txn %s if=%0b dm=%0b we=%0b ia=%h da=%h lat=%0d cycles=%0d", tag, want_if, want_dm, we, ia, da, lat, cyc);
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_req, if_done, dm_done, if_stall} !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset_ctrl got req/ifd/dmd/ifstall=%b exp=0001", {mem_req, if_done, dm_done, if_stall});
      end
      n_checks++;
      if ({if_rdata, dm_rdata, mem_addr, mem_wdata, 1'b0, mem_we} !== '0) begin
        n_fail++;
        $display("FAIL reset_data got if_rdata=%h dm_rdata=%h mem_addr=%h mem_wdata=%h mem_we=%b exp=0",
                 if_rdata, dm_rdata, mem_addr, mem_wdata, mem_we);
      end
    end
    reset = 1'b1;
    run_txn("reset_release", 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 1);
  endtask

  task automatic test_if_read();
    preload(32'h40, 32'h8C22_0004);
    run_txn("if_read", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 2);
    n_checks++;
    if (if_rdata !== 32'h8C22_0004) begin
      n_fail++;
      $display("FAIL if_read_value got=%h exp=8c220004", if_rdata);
    end
  endtask

  task automatic test_store();
    run_txn("store", 1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEAD_BEEF, 3);
    run_txn("load_back", 1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, 1);
    n_checks++;
    if (dm_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL store_readback got=%h exp=deadbeef", dm_rdata);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    preload(32'h104, 32'h0000_1234);
    preload(32'h48, 32'hAAAA_0048);
    run_txn("conflict1", 1'b1, 1'b1, 1'b0, 32'h48, 32'h104, 32'h0, 2);
    n_checks++;
    if (dm_rdata !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL conflict_dm_data got=%h exp=00001234", dm_rdata);
    end
    n_checks++;
    if (if_rdata !== 32'hAAAA_0048) begin
      n_fail++;
      $display("FAIL conflict_if_data got=%h exp=aaaa0048", if_rdata);
    end
    run_txn("conflict2", 1'b1, 1'b1, 1'b0, 32'h4C, 32'h104, 32'h0, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int kind;
      bit we;
      logic [31:0] ia, da, wd;
      kind = $urandom_range(0, 2);
      we   = 1'($urandom_range(0, 1));
      ia   = 32'($urandom_range(0, 255)) << 2;
      da   = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      wd   = $urandom();
      run_txn("b2b", kind != 1, kind != 0, we, ia, da, wd, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  task automatic test_spurious_ack();
    auto_mem = 1'b0;
    force_ack = 1'b1;
    force_rdata = 32'hFACE_0FF5;
    @(negedge clk);
    force_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({if_done, dm_done, mem_req} !== 3'b000) begin
        n_fail++;
        $display("FAIL spurious_ctrl got if_done=%b dm_done=%b mem_req=%b exp=000", if_done, dm_done, mem_req);
      end
      n_checks++;
      if (if_rdata !== m_if_rdata || dm_rdata !== m_dm_rdata || mem_addr !== m_last_addr) begin
        n_fail++;
        $display("FAIL spurious_data got if_rdata=%h dm_rdata=%h mem_addr=%h exp %h %h %h",
                 if_rdata, dm_rdata, mem_addr, m_if_rdata, m_dm_rdata, m_last_addr);
      end
    end
    auto_mem = 1'b1;
    @(negedge clk);
    run_txn("after_spurious", 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 1);
  endtask

  task automatic test_reset_midop();
    // make sure dm_rdata holds something nonzero before the reset clears it
    preload(32'h200, 32'h7777_0200);
    run_txn("pre_midop", 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 1);
    auto_mem = 1'b0;
    force_ack = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h204;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h204) begin
      n_fail++;
      $display("FAIL midop_grant got mem_req=%b mem_addr=%h exp 1 00000204", mem_req, mem_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    n_checks++;
    if ({mem_req, dm_done, if_done} !== 3'b000 || dm_rdata !== '0 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL midop_reset got mem_req=%b dm_done=%b dm_rdata=%h mem_addr=%h exp 0 0 0 0",
               mem_req, dm_done, dm_rdata, mem_addr);
    end
    reset = 1'b1;
    dm_req = 1'b0;
    force_ack = 1'b1;
    force_rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    force_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_req, dm_done, if_done} !== 3'b000 || dm_rdata !== '0) begin
        n_fail++;
        $display("FAIL midop_stray_ack got mem_req=%b dm_done=%b if_done=%b dm_rdata=%h exp 0 0 0 0",
                 mem_req, dm_done, if_done, dm_rdata);
      end
    end
    auto_mem = 1'b1;
    @(negedge clk);
    run_txn("after_midop", 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 2);
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_if_read();
    test_store();
    test_conflict();
    test_back_to_back();
    test_spurious_ack();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
